// File: rtl/window_comp_invoke_fsm1.sv
// Level-1 invoke controller for the window computation actor.
// Holds the CFDF mode, decides fireability from FIFO counts, issues a
// one-cycle start plus mode to the level-2 firing FSM, waits for its done,
// advances the mode and guards the wait with a sticky watchdog.
module window_comp_invoke_fsm1 #(
  parameter int size        = 3,
  parameter int buffer_size = 8,
  parameter int timeout     = 64,
  // Codebase log2 rounds up and yields 1 for an argument of 1.
  localparam int cw = ((buffer_size <= 1) ? 1 : $clog2(buffer_size)) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          invoke,
  input  logic [cw-1:0] pop_in_data,
  input  logic [cw-1:0] free_space_out,
  input  logic          done_in_child,
  output logic          enable,
  output logic          start_out,
  output logic [1:0]    next_mode_out,
  output logic          invoke_done,
  output logic          invoke_reject,
  output logic          busy,
  output logic          error
);

  localparam int cnt_w = (timeout <= 2) ? 1 : $clog2(timeout);
  localparam logic [cnt_w-1:0] count_last = cnt_w'(timeout - 1);
  localparam logic [cw-1:0]    size_cnt   = cw'(size);

  typedef enum logic [2:0] {
    STATE_IDLE       = 3'd0,
    STATE_FIRE_START = 3'd1,
    STATE_FIRE_WAIT  = 3'd2,
    STATE_END        = 3'd3
  } state_t;

  typedef enum logic [1:0] {
    MODE_SETUP_COMP = 2'b00,
    MODE_COMP       = 2'b01,
    MODE_OUTPUT     = 2'b10
  } mode_t;

  state_t           state, state_nxt;
  mode_t            mode, mode_nxt;
  logic [cnt_w-1:0] count, count_nxt;
  logic             error_nxt;
  logic             fireable;
  logic             reject_req;

  // Enable condition of the current mode; a tripped watchdog blocks all firing.
  always_comb begin
    fireable = 1'b0;
    case (mode)
      MODE_SETUP_COMP: fireable = (pop_in_data >= size_cnt);
      MODE_COMP:       fireable = 1'b1;
      default:         fireable = (free_space_out != '0);
    endcase
    enable = !error && fireable;
  end

  assign next_mode_out = mode;
  assign busy          = (state != STATE_IDLE);
  // Reject is a Mealy output; hold it low while reset is asserted.
  assign invoke_reject = reject_req && rst;

  // State, mode, watchdog counter and sticky error register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= STATE_IDLE;
      mode  <= MODE_SETUP_COMP;
      count <= '0;
      error <= 1'b0;
    end else begin
      state <= state_nxt;
      mode  <= mode_nxt;
      count <= count_nxt;
      error <= error_nxt;
    end
  end

  // Next-state, mode advance, watchdog and handshake outputs.
  always_comb begin
    state_nxt   = state;
    mode_nxt    = mode;
    count_nxt   = count;
    error_nxt   = error;
    start_out   = 1'b0;
    invoke_done = 1'b0;
    reject_req  = 1'b0;
    case (state)
      STATE_IDLE: begin
        if (invoke) begin
          if (enable) state_nxt  = STATE_FIRE_START;
          else        reject_req = 1'b1;
        end
      end
      STATE_FIRE_START: begin
        start_out = 1'b1;
        count_nxt = '0;
        state_nxt = STATE_FIRE_WAIT;
      end
      STATE_FIRE_WAIT: begin
        // Done takes priority over a watchdog expiry in the same cycle.
        if (done_in_child) begin
          state_nxt = STATE_END;
          case (mode)
            MODE_SETUP_COMP: mode_nxt = MODE_COMP;
            MODE_COMP:       mode_nxt = MODE_OUTPUT;
            default:         mode_nxt = MODE_SETUP_COMP;
          endcase
        end else if (count == count_last) begin
          state_nxt = STATE_IDLE;
          error_nxt = 1'b1;
        end else begin
          count_nxt = count + 1'b1;
        end
      end
      STATE_END: begin
        invoke_done = 1'b1;
        state_nxt   = STATE_IDLE;
      end
      default: state_nxt = STATE_IDLE;
    endcase
  end

endmodule

// File: tb/tb_window_comp_invoke_fsm1.sv
// Directed testbench for window_comp_invoke_fsm1 (size=3, buffer_size=8, timeout=64).
// Output vector obs = {start_out, invoke_done, invoke_reject, busy, error, enable, next_mode_out[1:0]}.
module tb_window_comp_invoke_fsm1;

  logic       clk = 1'b0;
  logic       rst;
  logic       invoke;
  logic [3:0] pop_in_data;
  logic [3:0] free_space_out;
  logic       done_in_child;
  logic       enable, start_out, invoke_done, invoke_reject, busy, error;
  logic [1:0] next_mode_out;
  logic [7:0] obs;
  int         total;
  int         bad;

  window_comp_invoke_fsm1 #(.size(3), .buffer_size(8), .timeout(64)) dut (
    .clk(clk), .rst(rst), .invoke(invoke), .pop_in_data(pop_in_data),
    .free_space_out(free_space_out), .done_in_child(done_in_child),
    .enable(enable), .start_out(start_out), .next_mode_out(next_mode_out),
    .invoke_done(invoke_done), .invoke_reject(invoke_reject), .busy(busy),
    .error(error)
  );

  assign obs = {start_out, invoke_done, invoke_reject, busy, error, enable, next_mode_out};

  always #5 clk = ~clk;

  // Advance to 2 time units after the next rising edge.
  task cyc();
    @(posedge clk);
    #2;
  endtask

  // Plain firing with the child done two cycles after start; no checks.
  task fire_quiet();
    invoke = 1'b1; cyc(); invoke = 1'b0; cyc(); cyc();
    done_in_child = 1'b1; cyc(); done_in_child = 1'b0; cyc();
  endtask

  task test_reset();
    #1 rst = 1'b0;
    #1;
    total++; if (obs !== 8'b0000_0100) begin bad++; $display("FAIL reset_state got=%b want=%b", obs, 8'b0000_0100); end
    pop_in_data = 4'd2;
    #1;
    total++; if (obs !== 8'b0000_0000) begin bad++; $display("FAIL reset_enable_pop2 got=%b want=%b", obs, 8'b0000_0000); end
    pop_in_data = 4'd3;
    cyc(); cyc();
    rst = 1'b1;
    cyc();
  endtask

  task test_full_cycle();
    logic [1:0] mcur, mnext;
    free_space_out = 4'd1;
    pop_in_data    = 4'd3;
    for (int m = 0; m < 3; m++) begin
      mcur  = 2'(m);
      mnext = (m == 2) ? 2'b00 : 2'(m + 1);
      invoke = 1'b1; #1;
      total++; if (obs !== {6'b000001, mcur}) begin bad++; $display("FAIL fc_idle got=%b want=%b", obs, {6'b000001, mcur}); end
      cyc(); invoke = 1'b0; #1;
      total++; if (obs !== {6'b100101, mcur}) begin bad++; $display("FAIL fc_start got=%b want=%b", obs, {6'b100101, mcur}); end
      cyc(); #1;
      total++; if (obs !== {6'b000101, mcur}) begin bad++; $display("FAIL fc_wait got=%b want=%b", obs, {6'b000101, mcur}); end
      cyc(); done_in_child = 1'b1; #1;
      total++; if (obs !== {6'b000101, mcur}) begin bad++; $display("FAIL fc_wait_done got=%b want=%b", obs, {6'b000101, mcur}); end
      cyc(); done_in_child = 1'b0; #1;
      total++; if (obs !== {6'b010101, mnext}) begin bad++; $display("FAIL fc_invoke_done got=%b want=%b", obs, {6'b010101, mnext}); end
      cyc(); #1;
      total++; if (obs !== {6'b000001, mnext}) begin bad++; $display("FAIL fc_back_idle got=%b want=%b", obs, {6'b000001, mnext}); end
    end
  endtask

  task test_not_fireable();
    pop_in_data = 4'd2; invoke = 1'b1; #1;
    total++; if (obs !== 8'b0010_0000) begin bad++; $display("FAIL nf_reject got=%b want=%b", obs, 8'b0010_0000); end
    cyc(); invoke = 1'b0; #1;
    total++; if (obs !== 8'b0000_0000) begin bad++; $display("FAIL nf_no_start got=%b want=%b", obs, 8'b0000_0000); end
    pop_in_data = 4'd3; invoke = 1'b1; #1;
    total++; if (obs !== 8'b0000_0100) begin bad++; $display("FAIL nf_ready got=%b want=%b", obs, 8'b0000_0100); end
    cyc(); invoke = 1'b0; #1;
    total++; if (obs !== 8'b1001_0100) begin bad++; $display("FAIL nf_start got=%b want=%b", obs, 8'b1001_0100); end
    cyc(); cyc(); done_in_child = 1'b1; cyc(); done_in_child = 1'b0; #1;
    total++; if (obs !== 8'b0101_0101) begin bad++; $display("FAIL nf_done got=%b want=%b", obs, 8'b0101_0101); end
    cyc();
  endtask

  task test_output_blocked();
    fire_quiet();
    free_space_out = 4'd0; invoke = 1'b1; #1;
    total++; if (obs !== 8'b0010_0010) begin bad++; $display("FAIL ob_reject got=%b want=%b", obs, 8'b0010_0010); end
    cyc(); invoke = 1'b0; #1;
    total++; if (obs !== 8'b0000_0010) begin bad++; $display("FAIL ob_idle got=%b want=%b", obs, 8'b0000_0010); end
    free_space_out = 4'd1; #1;
    total++; if (obs !== 8'b0000_0110) begin bad++; $display("FAIL ob_enable got=%b want=%b", obs, 8'b0000_0110); end
    invoke = 1'b1; cyc(); invoke = 1'b0; #1;
    total++; if (obs !== 8'b1001_0110) begin bad++; $display("FAIL ob_start got=%b want=%b", obs, 8'b1001_0110); end
    cyc(); cyc(); done_in_child = 1'b1; cyc(); done_in_child = 1'b0; #1;
    total++; if (obs !== 8'b0101_0100) begin bad++; $display("FAIL ob_done got=%b want=%b", obs, 8'b0101_0100); end
    cyc(); #1;
    total++; if (obs !== 8'b0000_0100) begin bad++; $display("FAIL ob_idle_after got=%b want=%b", obs, 8'b0000_0100); end
  endtask

  task test_busy_spurious();
    invoke = 1'b1; #1;
    total++; if (obs !== 8'b0000_0100) begin bad++; $display("FAIL bs_idle got=%b want=%b", obs, 8'b0000_0100); end
    cyc(); #1;
    total++; if (obs !== 8'b1001_0100) begin bad++; $display("FAIL bs_start got=%b want=%b", obs, 8'b1001_0100); end
    cyc(); #1;
    total++; if (obs !== 8'b0001_0100) begin bad++; $display("FAIL bs_no_restart got=%b want=%b", obs, 8'b0001_0100); end
    cyc(); done_in_child = 1'b1; #1;
    total++; if (obs !== 8'b0001_0100) begin bad++; $display("FAIL bs_wait got=%b want=%b", obs, 8'b0001_0100); end
    cyc(); done_in_child = 1'b0; #1;
    total++; if (obs !== 8'b0101_0101) begin bad++; $display("FAIL bs_end got=%b want=%b", obs, 8'b0101_0101); end
    cyc(); #1;
    total++; if (obs !== 8'b0000_0101) begin bad++; $display("FAIL bs_idle_again got=%b want=%b", obs, 8'b0000_0101); end
    invoke = 1'b0;
    cyc(); #1;
    total++; if (obs !== 8'b0000_0101) begin bad++; $display("FAIL bs_no_second_start got=%b want=%b", obs, 8'b0000_0101); end
    done_in_child = 1'b1; cyc(); done_in_child = 1'b0; #1;
    total++; if (obs !== 8'b0000_0101) begin bad++; $display("FAIL bs_spurious_done got=%b want=%b", obs, 8'b0000_0101); end
    cyc();
  endtask

  task test_watchdog_done_last();
    invoke = 1'b1; cyc(); invoke = 1'b0; #1;
    total++; if (obs !== 8'b1001_0101) begin bad++; $display("FAIL wdl_start got=%b want=%b", obs, 8'b1001_0101); end
    cyc();
    repeat (63) cyc();
    #1;
    total++; if (obs !== 8'b0001_0101) begin bad++; $display("FAIL wdl_last_wait got=%b want=%b", obs, 8'b0001_0101); end
    done_in_child = 1'b1; cyc(); done_in_child = 1'b0; #1;
    total++; if (obs !== 8'b0101_0110) begin bad++; $display("FAIL wdl_done got=%b want=%b", obs, 8'b0101_0110); end
    cyc(); #1;
    total++; if (obs !== 8'b0000_0110) begin bad++; $display("FAIL wdl_idle got=%b want=%b", obs, 8'b0000_0110); end
  endtask

  task test_watchdog();
    invoke = 1'b1; cyc(); invoke = 1'b0; #1;
    total++; if (obs !== 8'b1001_0110) begin bad++; $display("FAIL wd_start got=%b want=%b", obs, 8'b1001_0110); end
    cyc();
    repeat (63) cyc();
    #1;
    total++; if (obs !== 8'b0001_0110) begin bad++; $display("FAIL wd_last_wait got=%b want=%b", obs, 8'b0001_0110); end
    cyc(); #1;
    total++; if (obs !== 8'b0000_1010) begin bad++; $display("FAIL wd_expired got=%b want=%b", obs, 8'b0000_1010); end
    invoke = 1'b1; #1;
    total++; if (obs !== 8'b0010_1010) begin bad++; $display("FAIL wd_reject got=%b want=%b", obs, 8'b0010_1010); end
    cyc(); invoke = 1'b0; #1;
    total++; if (obs !== 8'b0000_1010) begin bad++; $display("FAIL wd_no_start got=%b want=%b", obs, 8'b0000_1010); end
    done_in_child = 1'b1; cyc(); done_in_child = 1'b0; #1;
    total++; if (obs !== 8'b0000_1010) begin bad++; $display("FAIL wd_sticky got=%b want=%b", obs, 8'b0000_1010); end
  endtask

  task test_reset_mid_fire();
    rst = 1'b0; #1;
    total++; if (obs !== 8'b0000_0100) begin bad++; $display("FAIL rm_clear_error got=%b want=%b", obs, 8'b0000_0100); end
    cyc(); rst = 1'b1; cyc();
    free_space_out = 4'd0; pop_in_data = 4'd3;
    invoke = 1'b1; cyc(); invoke = 1'b0; cyc(); cyc(); #1;
    total++; if (obs !== 8'b0001_0100) begin bad++; $display("FAIL rm_in_wait got=%b want=%b", obs, 8'b0001_0100); end
    rst = 1'b0; #1;
    total++; if (obs !== 8'b0000_0100) begin bad++; $display("FAIL rm_async got=%b want=%b", obs, 8'b0000_0100); end
    cyc(); rst = 1'b1; cyc(); #1;
    total++; if (obs !== 8'b0000_0100) begin bad++; $display("FAIL rm_post got=%b want=%b", obs, 8'b0000_0100); end
  endtask

  initial begin
    total          = 0;
    bad            = 0;
    rst            = 1'b1;
    invoke         = 1'b0;
    pop_in_data    = 4'd3;
    free_space_out = 4'd0;
    done_in_child  = 1'b0;
    test_reset();
    test_full_cycle();
    test_not_fireable();
    test_output_blocked();
    test_busy_spurious();
    test_watchdog_done_last();
    test_watchdog();
    test_reset_mid_fire();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
